// File: rtl/barrel_shifter_pipe.sv
// Pipelined SLL/SRL/SRA barrel shifter: one log-shifter layer per stage, valid/ready handshake,
// global stall. ROR support is compiled in only when BARREL_SHIFTER_ROTATE_EN is defined.
module barrel_shifter_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             err,
    output logic             busy
);

    localparam int STAGES = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROR = 2'd3
    } op_t;

    // Slot 0 holds the raw accepted op; slot k+1 holds it after layer k; slot STAGES is the output.
    logic             valid_reg [0:STAGES];
    logic [WIDTH-1:0] data_reg  [0:STAGES];
    logic             err_reg   [0:STAGES];
    logic             sign_reg  [0:STAGES-1];
    op_t              op_reg    [0:STAGES-1];
    logic             ovf_reg   [0:STAGES-1];
    logic [STAGES-1:0] amt_reg  [0:STAGES-1];

    logic [WIDTH-1:0] layer_data [0:STAGES-1];
    logic [WIDTH-1:0] final_data;
    logic             adv;
    op_t              op_in;
    logic             err_in;

    function automatic logic [WIDTH-1:0] shift_layer(
        input logic [WIDTH-1:0] d,
        input logic             s,
        input op_t              op,
        input int               sh
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   res;
        ext = {{WIDTH{s}}, d};
        res = d;
        case (op)
            OP_SLL: res = d << sh;
            OP_SRL: res = d >> sh;
            OP_SRA: begin
                ext = ext >> sh;
                res = ext[WIDTH-1:0];
            end
`ifdef BARREL_SHIFTER_ROTATE_EN
            OP_ROR: res = (d >> sh) | (d << (WIDTH - sh));
`endif
            default: res = d;
        endcase
        return res;
    endfunction

    assign adv       = !valid_reg[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_reg[STAGES];
    assign dataOut   = data_reg[STAGES];
    assign err       = err_reg[STAGES];

    always_comb begin
        op_in  = OP_SLL;
        err_in = 1'b0;
        case (Signal)
            6'b000000: op_in = OP_SLL;
            6'b000010: op_in = OP_SRL;
            6'b000011: op_in = OP_SRA;
`ifdef BARREL_SHIFTER_ROTATE_EN
            6'b000110: op_in = OP_ROR;
`endif
            default:   err_in = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_layer
            localparam int SH = 1 << gi;
            assign layer_data[gi] = amt_reg[gi][gi]
                ? shift_layer(data_reg[gi], sign_reg[gi], op_reg[gi], SH)
                : data_reg[gi];
        end
    endgenerate

    // Overshift and unsupported codes are resolved as the op enters the output slot.
    always_comb begin
        final_data = layer_data[STAGES-1];
        if (err_reg[STAGES-1]) begin
            final_data = '0;
        end else if (ovf_reg[STAGES-1] && op_reg[STAGES-1] != OP_ROR) begin
            final_data = (op_reg[STAGES-1] == OP_SRA) ? {WIDTH{sign_reg[STAGES-1]}} : '0;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= STAGES; k++) begin
            busy = busy | valid_reg[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                data_reg[k]  <= '0;
                err_reg[k]   <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                sign_reg[k] <= 1'b0;
                op_reg[k]   <= OP_SLL;
                ovf_reg[k]  <= 1'b0;
                amt_reg[k]  <= '0;
            end
        end else if (adv) begin
            valid_reg[0] <= in_valid;
            data_reg[0]  <= dataA;
            err_reg[0]   <= err_in;
            sign_reg[0]  <= dataA[WIDTH-1];
            op_reg[0]    <= op_in;
            ovf_reg[0]   <= |dataB[WIDTH-1:STAGES];
            amt_reg[0]   <= dataB[STAGES-1:0];
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k+1] <= valid_reg[k];
                err_reg[k+1]   <= err_reg[k];
                data_reg[k+1]  <= (k == STAGES - 1) ? final_data : layer_data[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                sign_reg[k] <= sign_reg[k-1];
                op_reg[k]   <= op_reg[k-1];
                ovf_reg[k]  <= ovf_reg[k-1];
                amt_reg[k]  <= amt_reg[k-1];
            end
        end
    end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

- Parametrised, pipelined successor to the team's combinational 32-bit left barrel shifter.
- Performs SLL, SRL, SRA and optional ROR on a WIDTH-bit operand, with one log-shifter layer per pipeline stage.
- Sits in the ALU shift path behind a valid/ready handshake and sustains one operation per cycle.
- Stalls cleanly under downstream back-pressure.

## Interface
Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- STAGES, derived = clog2(WIDTH), not overridable; pipeline depth and shift-amount width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted this cycle when in_valid && in_ready
- dataA  input  WIDTH  operand to shift
- dataB  input  WIDTH  shift amount; low STAGES bits = amount, upper bits = overshift
- Signal  input  6  function code: SLL 6'b000000, SRL 6'b000010, SRA 6'b000011, ROR 6'b000110
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- dataOut  output  WIDTH  shifted result
- err  output  1  qualified by out_valid; the op carried an unsupported Signal code
- busy  output  1  any stage holds a valid op

## Operation
- Shift amount: amt = dataB[STAGES-1:0]; ovf = |dataB[WIDTH-1:STAGES].
- SLL: dataA << amt, zero fill; if ovf, result 0.
- SRL: dataA >> amt, zero fill; if ovf, result 0.
- SRA: dataA >>> amt, fill with dataA[WIDTH-1]; if ovf, result is all copies of the sign bit.
- ROR: rotate right by amt; ovf is ignored (amount taken modulo WIDTH). Present only with the configuration macro.
- Unsupported Signal code: dataOut 0, err 1. The op still occupies a slot and is emitted in order.
- Stage k (k = 0..STAGES-1) applies the 2^k layer conditioned on amt[k].
- Each stage carries valid, data, sign, op class, ovf and err.
- Global advance enable: adv = !out_valid || out_ready.
  - On adv, all stages shift forward one slot and stage 0 captures the input.
  - Bubbles advance like ops; there is no compaction.
- in_ready = adv (combinational from out_valid/out_ready only).
- Ordering is strictly FIFO; no op is dropped or duplicated.
- busy = OR of all stage valid bits, including the output stage.

## Timing
- Reset (synchronous, dominant over every other input):
  - All valid bits are cleared; out_valid = 0, dataOut = 0, err = 0, busy = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Latency: an op accepted at edge N produces out_valid = 1 after edge N+STAGES (5 cycles at WIDTH=32) when no stall occurs.
- Throughput: 1 op/cycle while out_ready = 1.
- Stall:
  - out_valid && !out_ready holds every stage, dataOut and err stable, and drives in_ready = 0.
  - in_valid/dataA/dataB/Signal are ignored while in_ready = 0.
- Simultaneous out handshake and new input in the same cycle: both take effect; there is no bubble.
- Reset mid-operation: every in-flight op is discarded and nothing is emitted; out_valid = 0 from the cycle after the reset edge.
- Amount 0: result = dataA for every supported op.
- Amount WIDTH-1 with ovf = 0 is a legal maximum shift.

## Configuration
- BARREL_SHIFTER_ROTATE_EN defined: ROR code 6'b000110 is supported, with err = 0.
- Not defined: the rotate datapath is not compiled. ROR code returns dataOut 0 with err = 1, like any unsupported code.
- SLL/SRL/SRA behaviour and timing are identical in both builds.

## Test plan
All scenarios at WIDTH=32.
- SLL: dataA=0x00000001, dataB=31 -> dataOut 0x80000000, out_valid exactly 5 cycles after accept.
- SRL/SRA: dataA=0x80000000, dataB=4 -> SRL 0x08000000, SRA 0xF8000000.
- Overshift: dataB=32 with SLL on 0x12345678 -> 0; SRA on 0x80000001 -> 0xFFFFFFFF; SRL on 0xFFFFFFFF -> 0.
- Back-pressure:
  - Stimulus: 8 back-to-back SLL ops with amounts 0..7 on 0x1; out_ready low for 3 cycles after the first result.
  - Response: 8 results 0x1..0x80 in order; in_ready = 0 exactly during the stall; no loss.
- Rotate: ROR 0x000000F1 by 4 -> 0x1000000F with macro; without macro -> dataOut 0, err = 1. Signal 6'b111111 -> err = 1 in both builds.
- Reset mid-flight: 3 ops in flight, reset high 1 cycle -> out_valid 0 and busy 0 the next cycle; no result emitted; a new op afterwards completes in 5 cycles.
